// File: rtl/bos_spi_responder.sv
// bos_spi_responder: SPI mode-0 slave register model for 24-bit BOS control frames.
// Define BOS_SPI_RESP_ERRCNT_EN to count aborted frames on err_cnt.
module bos_spi_responder #(
    parameter int N_REGS      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic        wr_valid,
    output logic [6:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        rd_valid,
    input  logic [6:0]  loc_addr,
    output logic [15:0] loc_data,
    output logic [7:0]  err_cnt
);
    localparam int AW = N_REGS > 1 ? $clog2(N_REGS) : 1;

    typedef enum logic [1:0] {IDLE, HDR, DATA, OVER} state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
    logic        cs_prev_q, sclk_prev_q;
    logic        cs_s, sclk_s, mosi_s, cs_fall, cs_rise, s_rise, s_fall;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [23:0] frm_q, frm_d;
    logic [7:0]  hdr_next;
    logic [15:0] sh_q, sh_d, rd_word;
    logic        rd_q, rd_d, bit_q, bit_d, miso_q, miso_d;
    logic        wr_valid_q, wr_valid_d, rd_valid_q, rd_valid_d;
    logic [6:0]  wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic [15:0] regs_q [N_REGS];
    logic [15:0] regs_d [N_REGS];

    function automatic logic in_range(input logic [6:0] a);
        return {1'b0, a} < 8'(N_REGS);
    endfunction

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign cs_fall  = cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;
    assign s_rise   = ~sclk_prev_q & sclk_s;
    assign s_fall   = sclk_prev_q & ~sclk_s;
    assign hdr_next = {frm_q[6:0], mosi_s};
    assign rd_word  = in_range(hdr_next[6:0]) ? regs_q[hdr_next[AW-1:0]] : 16'h0;
    assign loc_data = in_range(loc_addr) ? regs_q[loc_addr[AW-1:0]] : 16'h0;
    assign miso     = miso_q;
    assign wr_valid = wr_valid_q;
    assign rd_valid = rd_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frm_d      = frm_q;
        rd_d       = rd_q;
        sh_d       = sh_q;
        bit_d      = bit_q;
        regs_d     = regs_q;
        wr_valid_d = 1'b0;
        rd_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        // cs_n rising takes priority over any sclk edge seen in the same cycle
        if (state_q != IDLE && cs_rise) begin
            state_d = IDLE;
            if (cnt_q == 5'd24 && !frm_q[23]) begin
                wr_valid_d = 1'b1;
                wr_addr_d  = frm_q[22:16];
                wr_data_d  = frm_q[15:0];
                if (in_range(frm_q[22:16])) regs_d[frm_q[16 +: AW]] = frm_q[15:0];
            end else if (cnt_q == 5'd24) begin
                rd_valid_d = 1'b1;
            end
        end else if (state_q == IDLE) begin
            if (cs_fall) begin
                state_d = HDR;
                cnt_d   = 5'd0;
                rd_d    = 1'b0;
                bit_d   = 1'b0;
            end
        end else if (s_rise) begin
            if (state_q == OVER) begin
                cnt_d = cnt_q == 5'd25 ? cnt_q : cnt_q + 5'd1;
            end else begin
                frm_d = {frm_q[22:0], mosi_s};
                cnt_d = cnt_q + 5'd1;
                if (state_q == HDR && cnt_q == 5'd7) begin
                    state_d = DATA;
                    rd_d    = hdr_next[7];
                    sh_d    = rd_word;
                    bit_d   = 1'b0;
                end
                if (state_q == DATA && cnt_q == 5'd23) state_d = OVER;
            end
        end else if (s_fall && state_q == DATA) begin
            bit_d = sh_q[15];
            sh_d  = {sh_q[14:0], 1'b0};
        end
        miso_d = state_q == DATA && rd_q && bit_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            frm_q       <= '0;
            rd_q        <= 1'b0;
            sh_q        <= '0;
            bit_q       <= 1'b0;
            miso_q      <= 1'b0;
            wr_valid_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frm_q       <= frm_d;
            rd_q        <= rd_d;
            sh_q        <= sh_d;
            bit_q       <= bit_d;
            miso_q      <= miso_d;
            wr_valid_q  <= wr_valid_d;
            rd_valid_q  <= rd_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            regs_q      <= regs_d;
        end
    end

`ifdef BOS_SPI_RESP_ERRCNT_EN
    logic [7:0] err_q, err_d;
    logic       abort;
    assign abort   = state_q != IDLE && cs_rise && cnt_q != 5'd24;
    assign err_d   = abort && err_q != 8'hFF ? err_q + 8'd1 : err_q;
    assign err_cnt = err_q;
    always_ff @(posedge clk) begin
        if (rst) err_q <= '0;
        else     err_q <= err_d;
    end
`else
    assign err_cnt = 8'h0;
`endif
endmodule
